mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder_pkg.sv | 32 +++
 rtl/mem_line_responder_if.sv | 36 +++
 rtl/mem_line_store.sv | 33 +++
 rtl/mem_line_responder.sv | 129 ++++++++++++
 tb/tb_mem_line_responder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_responder_pkg
//  Purpose  : Shared constants and state encodings for the line responder
//             and the cache controller that talks to it.
//  Revision : 1.0  initial release
// ============================================================================
package mem_line_responder_pkg;

    // A cache line is four words; the beat counter addresses them.
    localparam int C_WORDS_PER_LINE = 4;
    localparam int C_BEAT_W         = 2;

    // Responder FSM encoding. Encodings 5..7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } resp_state_e;

    // Cache controller side state encoding, shared so both ends agree.
    typedef enum logic [1:0] {
        CC_IDLE   = 2'd0,
        CC_LOOKUP = 2'd1,
        CC_EVICT  = 2'd2,
        CC_FILL   = 2'd3
    } cc_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_line_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_responder_if
//  Purpose  : Request / writeback / fill channels between cache controller
//             (master) and line responder (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_line_responder_if #(
    parameter int DATA_W      = 32,
    parameter int LINE_ADDR_W = 6
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic                   wvalid;
    logic [DATA_W-1:0]      wdata;
    logic                   wready;
    logic                   rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   rlast;
    logic                   rready;
    logic                   done;
    logic [2:0]             state_out;

    modport master (
        output req_valid, req_write, req_addr, wvalid, wdata, rready,
        input  req_ready, wready, rvalid, rdata, rlast, done, state_out
    );

    modport slave (
        input  req_valid, req_write, req_addr, wvalid, wdata, rready,
        output req_ready, wready, rvalid, rdata, rlast, done, state_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_line_store.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_store
//  Purpose  : Word storage for all lines; one synchronous write port and one
//             asynchronous read port. Contents are not affected by reset.
//  Revision : 1.0  initial release
// ============================================================================
module mem_line_store #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);
    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [C_DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_responder
//  Purpose  : Memory-side responder for cache line fills and writebacks.
//             Accepts one line request, waits LATENCY cycles, then moves four
//             data beats in the requested direction and pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LINE_ADDR_W = 6,
    parameter int LATENCY     = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_line_responder_if.slave  bus
);
    localparam int                    C_MEM_AW    = LINE_ADDR_W + C_BEAT_W;
    localparam logic [3:0]            C_WAIT_LAST = 4'(LATENCY - 1);
    localparam logic [C_BEAT_W-1:0]   C_LAST_BEAT = C_BEAT_W'(C_WORDS_PER_LINE - 1);

    resp_state_e            state_q, state_d;
    logic [C_BEAT_W-1:0]    beat_q, beat_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic                   write_q, write_d;

    logic                   w_mem_we;
    logic [C_MEM_AW-1:0]    w_mem_addr;
    logic [DATA_W-1:0]      w_mem_rdata;

    // State and captured-request registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
        end
    end

    // Next-state logic; inputs are only looked at in the state that owns them.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        w_mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    write_d    = bus.req_write;
                    wait_cnt_d = '0;
                    beat_d     = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == C_WAIT_LAST) begin
                    wait_cnt_d = '0;
                    beat_d     = '0;
                    state_d    = write_q ? ST_WR_DATA : ST_RD_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_WR_DATA: begin
                if (bus.wvalid) begin
                    w_mem_we = 1'b1;
                    beat_d   = beat_q + C_BEAT_W'(1);
                    if (beat_q == C_LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD_DATA: begin
                if (bus.rready) begin
                    beat_d = beat_q + C_BEAT_W'(1);
                    if (beat_q == C_LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reads and writes share one word address: captured line plus beat.
    assign w_mem_addr = {addr_q, beat_q};

    mem_line_store #(
        .DATA_W (DATA_W),
        .ADDR_W (C_MEM_AW)
    ) u_store (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_addr),
        .i_wdata (bus.wdata),
        .i_raddr (w_mem_addr),
        .o_rdata (w_mem_rdata)
    );

    // Handshake outputs depend on state and beat only.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.wready    = (state_q == ST_WR_DATA);
    assign bus.rvalid    = (state_q == ST_RD_DATA);
    assign bus.rlast     = (state_q == ST_RD_DATA) && (beat_q == C_LAST_BEAT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.state_out = state_q;
    assign bus.rdata     = w_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_line_responder
//  Purpose  : Directed self-checking bench for mem_line_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_line_responder;
    localparam int C_DATA_W = 32;
    localparam int C_LAW    = 6;
    localparam int C_LAT    = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mem_line_responder_if #(.DATA_W(C_DATA_W), .LINE_ADDR_W(C_LAW)) bus ();

    mem_line_responder #(
        .DATA_W      (C_DATA_W),
        .LINE_ADDR_W (C_LAW),
        .LATENCY     (C_LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_wready"},    32'(bus.wready),    32'd0);
        check({tag, "_rvalid"},    32'(bus.rvalid),    32'd0);
        check({tag, "_rlast"},     32'(bus.rlast),     32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_state"},     32'(bus.state_out), 32'd0);
    endtask

    // Presents a request in IDLE and returns 1 time unit after the accept edge.
    task automatic start_req(input logic wr, input logic [C_LAW-1:0] addr, input logic hold);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    // Writeback of base..base+3 with wvalid held high throughout.
    task automatic wb_check(input logic [C_LAW-1:0] addr, input logic [31:0] base, input logic hold);
        int exp_st;
        bus.wvalid = 1'b1;
        bus.wdata  = base;
        start_req(1'b1, addr, hold);
        for (int cyc = 0; cyc <= C_LAT + 5; cyc++) begin
            if (cyc < C_LAT)            exp_st = 1;
            else if (cyc < C_LAT + 4)   exp_st = 2;
            else if (cyc == C_LAT + 4)  exp_st = 4;
            else                        exp_st = 0;
            if (exp_st == 2) bus.wdata = base + 32'(cyc - C_LAT);
            check("wb_state",     32'(bus.state_out), 32'(exp_st));
            check("wb_wready",    32'(bus.wready),    32'(exp_st == 2));
            check("wb_done",      32'(bus.done),      32'(exp_st == 4));
            check("wb_req_ready", 32'(bus.req_ready), 32'(exp_st == 0));
            if (cyc != C_LAT + 5) begin
                @(posedge clk); #1;
            end
        end
        bus.wvalid = 1'b0;
    endtask

    // Fill expecting base..base+3; optional stall on beat 1 and stray wvalid pulses.
    task automatic fill_check(input logic [C_LAW-1:0] addr, input logic [31:0] base,
                              input int stall, input logic wpulse);
        int  beat;
        int  stalls;
        bit  fin;
        beat   = 0;
        stalls = stall;
        fin    = 1'b0;
        bus.rready = 1'b1;
        start_req(1'b0, addr, 1'b0);
        for (int c = 0; c < C_LAT; c++) begin
            bus.wvalid = wpulse && (c % 2 == 0);
            bus.wdata  = 32'hDEAD_0000 + 32'(c);
            check("fill_wait_state",  32'(bus.state_out), 32'd1);
            check("fill_wait_rvalid", 32'(bus.rvalid),    32'd0);
            @(posedge clk); #1;
        end
        for (int c = 0; c < 20 && !fin; c++) begin
            bus.rready = !(beat == 1 && stalls > 0);
            bus.wvalid = wpulse && (c % 2 == 0);
            bus.wdata  = 32'hBEEF_0000 + 32'(c);
            check("fill_rvalid", 32'(bus.rvalid),    32'd1);
            check("fill_rdata",  bus.rdata,          base + 32'(beat));
            check("fill_rlast",  32'(bus.rlast),     32'(beat == 3));
            check("fill_done",   32'(bus.done),      32'd0);
            if (!bus.rready) stalls--;
            @(posedge clk); #1;
            if (bus.rready) begin
                if (beat == 3) fin = 1'b1;
                else           beat++;
            end
        end
        bus.wvalid = 1'b0;
        bus.rready = 1'b0;
        check("fill_finished", 32'(fin), 32'd1);
        check("fill_done_pulse", 32'(bus.done),      32'd1);
        check("fill_done_state", 32'(bus.state_out), 32'd4);
        check("fill_done_rvalid", 32'(bus.rvalid),   32'd0);
        @(posedge clk); #1;
        check_idle_outputs("fill_end");
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        bus.rready    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        // Writeback line 5, then plain fill, then fill with a 3-cycle stall on beat 1.
        wb_check(6'd5, 32'h0000_00A0, 1'b0);
        fill_check(6'd5, 32'h0000_00A0, 0, 1'b0);
        fill_check(6'd5, 32'h0000_00A0, 3, 1'b0);

        // Reset asserted mid-cycle while fill beat 2 is on the bus.
        bus.rready = 1'b1;
        start_req(1'b0, 6'd5, 1'b0);
        repeat (C_LAT + 2) @(posedge clk);
        #1;
        check("rst_fill_pre_rdata", bus.rdata, 32'h0000_00A2);
        check("rst_fill_pre_state", 32'(bus.state_out), 32'd3);
        #3 rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_fill");
        @(posedge clk); #1;
        check_idle_outputs("rst_mid_fill_held");
        rst = 1'b0;
        bus.rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", 32'(bus.done),      32'd0);
            check("post_rst_idle",    32'(bus.state_out), 32'd0);
        end
        fill_check(6'd5, 32'h0000_00A0, 0, 1'b0);

        // req_valid held through the whole writeback: only re-accepted from IDLE,
        // which here becomes a fill of the same line with stray wvalid pulses.
        wb_check(6'd9, 32'h0000_00B0, 1'b1);
        fill_check(6'd9, 32'h0000_00B0, 0, 1'b1);
        fill_check(6'd9, 32'h0000_00B0, 0, 1'b0);
        fill_check(6'd5, 32'h0000_00A0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
`default_nettype wire
